// File: rtl/stdp_weight_scheduler_pkg.sv
// stdp_ctrl_pkg: shared types for the STDP weight-update scheduler.
//   dir_e      : update direction (DIR_DEC=0, DIR_INC=1)
//   pend_t     : one-deep pending slot {v, dir}
//   DROP_CNT_W : width of the filtered-update counter
package stdp_ctrl_pkg;

  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } dir_e;

  typedef struct packed {
    logic v;
    dir_e dir;
  } pend_t;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/stdp_weight_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     in  N        request vector
//   ptr     in  IW       highest-priority index this cycle
//   gnt     out N        one-hot grant (zero when no request)
//   gnt_idx out IW       index of the granted requester
//   gnt_vld out 1        any grant this cycle
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
    end
  end

endmodule

// File: rtl/stdp_weight_scheduler.sv
// stdp_weight_scheduler: funnels per-synapse STDP inc/dec requests into
// single-cycle, one-hot pulses for a bank of saturating weight counters.
//   clk, rst_n      clock / synchronous active-low reset
//   upd_en          gate issue (capture continues when low)
//   req_valid/dir   per-synapse request, dir 1 = inc, 0 = dec
//   weight_in       current weights, synapse i at [i*W +: W]
//   cnt_inc/dec     registered one-hot pulses to the counter bank
//   busy            any slot pending or pulse in flight
//   ovf             sticky: a same-direction request collided with a slot
//   drop_cnt        saturating count of filtered updates
// Optional: define STDP_SAT_FILTER_EN to drop updates that would push a
// weight past its saturation bound (drop_cnt tied 0 otherwise).
module stdp_weight_scheduler
  import stdp_ctrl_pkg::*;
#(
  parameter int N_SYN = 8,
  parameter int W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_en,
  input  logic [N_SYN-1:0]      req_valid,
  input  logic [N_SYN-1:0]      req_dir,
  input  logic [N_SYN*W-1:0]    weight_in,
  output logic [N_SYN-1:0]      cnt_inc,
  output logic [N_SYN-1:0]      cnt_dec,
  output logic                  busy,
  output logic                  ovf,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int PW = $clog2(N_SYN);

  pend_t [N_SYN-1:0]         pend_q, pend_d;
  logic  [PW-1:0]            rr_ptr;
  logic  [N_SYN-1:0]         elig, gnt;
  logic  [PW-1:0]            gnt_idx;
  logic                      gnt_vld;
  dir_e                      gnt_dir;
  logic                      sat;
  logic                      ovf_set;
  logic  [N_SYN-1:0][W-1:0]  w_arr;

  assign w_arr = weight_in;

  // A synapse with a pulse on the wire is held off one cycle so the
  // weight seen at grant already reflects that pulse.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SYN; i++)
      elig[i] = pend_q[i].v & upd_en & ~cnt_inc[i] & ~cnt_dec[i];
  end

  rr_arbiter #(.N(N_SYN)) u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign gnt_dir = pend_q[gnt_idx].dir;

`ifdef STDP_SAT_FILTER_EN
  logic [DROP_CNT_W-1:0] drop_q;

  assign sat = gnt_vld &&
               ((gnt_dir == DIR_INC) ? (w_arr[gnt_idx] == {W{1'b1}})
                                     : (w_arr[gnt_idx] == '0));

  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_q <= '0;
    else if (sat && drop_q != {DROP_CNT_W{1'b1}})
      drop_q <= drop_q + 1'b1;
  end

  assign drop_cnt = drop_q;
`else
  logic unused_w;
  assign unused_w = ^w_arr;
  assign sat      = 1'b0;
  assign drop_cnt = '0;
`endif

  // Slot update. A grant consumes the old content first, so a request
  // landing on a granted slot simply reloads it.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    for (int i = 0; i < N_SYN; i++) begin
      if (gnt[i]) pend_d[i].v = 1'b0;
      if (req_valid[i]) begin
        if (gnt[i] || !pend_q[i].v) begin
          pend_d[i].v   = 1'b1;
          pend_d[i].dir = dir_e'(req_dir[i]);
        end else if (pend_q[i].dir == dir_e'(req_dir[i])) begin
          ovf_set = 1'b1;
        end else begin
          pend_d[i].v = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      rr_ptr  <= '0;
      cnt_inc <= '0;
      cnt_dec <= '0;
      ovf     <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      cnt_inc <= (gnt_vld && !sat && gnt_dir == DIR_INC) ? gnt : '0;
      cnt_dec <= (gnt_vld && !sat && gnt_dir == DIR_DEC) ? gnt : '0;
      if (ovf_set) ovf <= 1'b1;
      if (gnt_vld)
        rr_ptr <= (gnt_idx == PW'(N_SYN-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    busy = |cnt_inc | |cnt_dec;
    for (int i = 0; i < N_SYN; i++) busy = busy | pend_q[i].v;
  end

endmodule

// File: tb/tb_stdp_weight_scheduler.sv
// Directed bench for stdp_weight_scheduler (N_SYN=8, W=3). Inputs are
// driven 1 time unit after posedge, outputs sampled at the same point.
module tb_stdp_weight_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_en;
  logic [7:0]  req_valid;
  logic [7:0]  req_dir;
  logic [23:0] weight_in;
  logic [7:0]  cnt_inc;
  logic [7:0]  cnt_dec;
  logic        busy;
  logic        ovf;
  logic [7:0]  drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  stdp_weight_scheduler #(.N_SYN(8), .W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_en    (upd_en),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .weight_in (weight_in),
    .cnt_inc   (cnt_inc),
    .cnt_dec   (cnt_dec),
    .busy      (busy),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    upd_en    = 1'b1;
    req_valid = '0;
    req_dir   = '0;
    weight_in = '0;
    tick;
    tick;
    chk("rst_inc",  32'(cnt_inc),  32'h0);
    chk("rst_dec",  32'(cnt_dec),  32'h0);
    chk("rst_busy", 32'(busy),     32'h0);
    chk("rst_ovf",  32'(ovf),      32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    rst_n = 1'b1;

    // single inc on synapse 2: pulse E1..E2, busy E0..E2
    req_valid = 8'h04; req_dir = 8'h04;
    tick;
    req_valid = '0;
    chk("t1_e0_busy", 32'(busy), 32'h1);
    chk("t1_e0_inc",  32'(cnt_inc), 32'h0);
    tick;
    chk("t1_e1_inc",  32'(cnt_inc), 32'h04);
    chk("t1_e1_dec",  32'(cnt_dec), 32'h0);
    chk("t1_e1_busy", 32'(busy), 32'h1);
    tick;
    chk("t1_e2_inc",  32'(cnt_inc), 32'h0);
    chk("t1_e2_busy", 32'(busy), 32'h0);

    // all eight dec in one cycle: served 0..7 back to back
    do_reset;
    req_valid = 8'hFF; req_dir = 8'h00;
    tick;
    req_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk($sformatf("t2_dec%0d", k), 32'(cnt_dec), 32'(8'h01 << (k-1)));
      chk($sformatf("t2_inc%0d", k), 32'(cnt_inc), 32'h0);
    end
    tick;
    chk("t2_done_dec",  32'(cnt_dec), 32'h0);
    chk("t2_done_busy", 32'(busy), 32'h0);
    // pointer back at 0: synapse 0 must beat synapse 7
    req_valid = 8'h81; req_dir = 8'h00;
    tick;
    req_valid = '0;
    tick;
    chk("t2_ptr_first",  32'(cnt_dec), 32'h01);
    tick;
    chk("t2_ptr_second", 32'(cnt_dec), 32'h80);
    tick;
    chk("t2_ptr_idle",   32'(busy), 32'h0);

    // synapse 5 cancel (inc then dec) while disabled
    upd_en = 1'b0;
    req_valid = 8'h20; req_dir = 8'h20;
    tick;
    req_dir = 8'h00;
    tick;
    req_valid = '0;
    chk("t3_cancel_busy", 32'(busy), 32'h0);
    chk("t3_cancel_ovf",  32'(ovf), 32'h0);
    upd_en = 1'b1;
    tick;
    tick;
    chk("t3_cancel_inc", 32'(cnt_inc), 32'h0);
    chk("t3_cancel_dec", 32'(cnt_dec), 32'h0);
    // inc, inc while disabled: one pulse, ovf set
    upd_en = 1'b0;
    req_valid = 8'h20; req_dir = 8'h20;
    tick;
    tick;
    req_valid = '0;
    chk("t3_dup_ovf",  32'(ovf), 32'h1);
    chk("t3_dup_busy", 32'(busy), 32'h1);
    tick;
    chk("t3_hold_inc", 32'(cnt_inc), 32'h0);
    upd_en = 1'b1;
    tick;
    chk("t3_dup_inc", 32'(cnt_inc), 32'h20);
    tick;
    chk("t3_dup_inc_off", 32'(cnt_inc), 32'h0);
    chk("t3_dup_busy_off", 32'(busy), 32'h0);

    // synapse 3 hammering: pulse every other cycle
    do_reset;
    req_valid = 8'h08; req_dir = 8'h08;
    for (int t = 0; t < 8; t++) begin
      tick;
      chk($sformatf("t4_inc_t%0d", t), 32'(cnt_inc), (t % 2 == 1) ? 32'h08 : 32'h0);
    end
    req_valid = '0;
    tick; tick; tick;
    chk("t4_drain_busy", 32'(busy), 32'h0);

    // saturation filter
    do_reset;
    weight_in = 24'(7) << 3;            // synapse 1 at max, others 0
    req_valid = 8'h02; req_dir = 8'h02;
    tick;
    req_valid = '0;
    tick;
`ifdef STDP_SAT_FILTER_EN
    chk("t5_sat_inc",  32'(cnt_inc), 32'h0);
    chk("t5_sat_drop", 32'(drop_cnt), 32'h1);
`else
    chk("t5_sat_inc",  32'(cnt_inc), 32'h02);
    chk("t5_sat_drop", 32'(drop_cnt), 32'h0);
`endif
    tick;
    chk("t5_sat_busy", 32'(busy), 32'h0);
    req_valid = 8'h10; req_dir = 8'h00; // synapse 4 at 0, dec
    tick;
    req_valid = '0;
    tick;
`ifdef STDP_SAT_FILTER_EN
    chk("t5_zero_dec",  32'(cnt_dec), 32'h0);
    chk("t5_zero_drop", 32'(drop_cnt), 32'h2);
`else
    chk("t5_zero_dec",  32'(cnt_dec), 32'h10);
    chk("t5_zero_drop", 32'(drop_cnt), 32'h0);
`endif
    req_valid = 8'h02; req_dir = 8'h00; // synapse 1 at max, dec is fine
    tick;
    req_valid = '0;
    tick;
    chk("t5_ok_dec", 32'(cnt_dec), 32'h02);
    weight_in = '0;

    // reset with a pulse in flight and four slots pending
    do_reset;
    req_valid = 8'h1F; req_dir = 8'h1F;
    tick;
    req_valid = '0;
    tick;
    chk("t6_pre_inc", 32'(cnt_inc), 32'h01);
    rst_n = 1'b0;
    req_valid = 8'hFF; req_dir = 8'hFF;  // discarded by reset
    tick;
    rst_n = 1'b1;
    req_valid = '0;
    chk("t6_rst_inc",  32'(cnt_inc), 32'h0);
    chk("t6_rst_dec",  32'(cnt_dec), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_ovf",  32'(ovf), 32'h0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'h0);
    for (int t = 0; t < 4; t++) begin
      tick;
      chk($sformatf("t6_quiet%0d", t), 32'({cnt_inc, cnt_dec, 7'b0, busy}), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stdp_weight_scheduler.md
# stdp_weight_scheduler

Shares STDP weight-update traffic from `N_SYN` synapse learning units onto a bank of `N_SYN` saturating `W`-bit up/down weight counters. Captures per-synapse inc/dec requests into one-deep pending slots, issues at most one single-cycle inc or dec pulse per clock under round-robin order, and filters updates that would hit a saturated weight. Sits between the spike-timing learning logic and the weight counter bank in each neuron column.

## Interface
- `N_SYN`, 8, number of synapses/requesters (2..32)
- `W`, 3, weight counter width; saturation bounds 0 and 2^W-1
- `clk`  in  1  clock; all logic on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `upd_en`  in  1  when 0, requests still captured but nothing issued
- `req_valid`  in  N_SYN  per-synapse single-cycle update request
- `req_dir`  in  N_SYN  per-synapse direction: 1 = inc, 0 = dec; qualified by `req_valid`
- `weight_in`  in  N_SYN*W  current counter values, synapse i at bits [i*W +: W]
- `cnt_inc`  out  N_SYN  registered one-hot inc pulse to counter bank
- `cnt_dec`  out  N_SYN  registered one-hot dec pulse to counter bank
- `busy`  out  1  any pending slot set or pulse in flight
- `ovf`  out  1  sticky: a same-direction request was lost
- `drop_cnt`  out  8  saturating count of filtered (saturated) updates

## Operation
- Per synapse i: pending slot {`pend_v[i]`, `pend_dir[i]`}.
- Capture at each edge with `req_valid[i]`=1:
  - slot empty: load {1, `req_dir[i]`}
  - slot full, same dir: keep slot, set `ovf`
  - slot full, opposite dir: clear slot (net zero), no `ovf`
  - slot granted this cycle: grant consumes old content, new request loads the slot; no merge/cancel
- Eligibility: `pend_v[i]`=1, `upd_en`=1, and no pulse on `cnt_inc[i]`/`cnt_dec[i]` this cycle (in-flight exclusion keeps `weight_in` current).
- Arbitration: round-robin from pointer `rr_ptr` upward, wrapping at N_SYN-1 -> 0; at most one grant per cycle; after granting i, `rr_ptr` = (i+1) mod N_SYN; no grant -> pointer unchanged.
- Granted slot is cleared. Output pulse on next edge: inc if dir=1, dec if dir=0, unless filtered (Configuration).
- `cnt_inc`/`cnt_dec` never both nonzero; each at most one-hot; every pulse lasts exactly one cycle.
- `upd_en` falling: pending slots hold; a pulse already registered completes.
- `drop_cnt` saturates at 255.

## Timing
- Reset (`rst_n`=0 at edge): all slots empty, `rr_ptr`=0, `cnt_inc`=0, `cnt_dec`=0, `busy`=0, `ovf`=0, `drop_cnt`=0. Requests in the reset cycle are discarded.
- Latency: request sampled at edge E0 -> slot set after E0 -> grant during cycle E0..E1 -> pulse high E1..E2 -> counter updates at E2. Minimum 2 edges request-to-pulse.
- Throughput: one pulse per cycle; the same synapse at most every other cycle.
- `weight_in` sampled combinationally in the grant cycle only.
- `busy` combinational from slot and pulse registers.

## Configuration
- `STDP_SAT_FILTER_EN` defined: a grant with dir=1 and weight=2^W-1, or dir=0 and weight=0, clears the slot, issues no pulse, and increments `drop_cnt`; `rr_ptr` still advances.
- Undefined: pulses always issued (counter saturates itself); `drop_cnt` tied 0; `weight_in` unused.

## Structure
- Package `stdp_ctrl_pkg`: `dir_e` enum (`DIR_DEC`=0, `DIR_INC`=1), `pend_t` struct {v, dir}, `DROP_CNT_W`=8.
- Sub-module `rr_arbiter` (parameter N): request vector + pointer in, one-hot grant + grant index out. Purely combinational; the pointer register lives in the top.
- Top holds slots, pointer, output pulse registers, filter, `ovf`, `drop_cnt`.

## Test plan
- Reset release, req_valid[2]=1 dir=1 at E0 -> cnt_inc = 8'b0000_0100 during E1..E2 only; busy 1 from E0 to E2.
- req_valid = 8'hFF all dir=0 in one cycle -> cnt_dec pulses synapses 0,1,...,7 on eight consecutive cycles; pointer ends at 0.
- Synapse 5: inc at E0, dec at E1 before grant with upd_en=0 -> slot cleared, no pulse, ovf=0; repeat with inc,inc -> one inc pulse after upd_en=1, ovf=1.
- Only synapse 3 requesting every cycle -> pulses on 3 every other cycle, never back-to-back.
- Macro on, weight_in[1]=3'b111, inc on synapse 1 -> no pulse, drop_cnt=1; macro off -> cnt_inc[1] pulses, drop_cnt=0.
- rst_n=0 for one edge while pulse in flight and 4 slots pending -> next cycle all outputs 0, no further pulses.
